coin_acceptor: RTL and testbench
================================

Name: coin_acceptor

Overview:
- Front end that drives the 2-bit coin code into the newspaper vending controller (00 none, 01 five points, 10 ten points).
- Takes raw mechanical coin-detector levels, synchronizes and debounces them, and turns each physical coin into one coin event.
- Buffers the events in a small FIFO.
- Emits one-cycle coin codes paced so that no coin arrives while the controller is dispensing (nw_pa high), because a coin presented then would be lost.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive synchronized cycles a detector level must hold before it is accepted (range 2..15).
- FIFO_DEPTH, 4: coin events buffered; must be a power of 2, at least 2.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- det5  input  1  raw five-point detector level; asynchronous and bouncy.
- det10  input  1  raw ten-point detector level; asynchronous and bouncy.
- nw_pa  input  1  newspaper-dispense indication from the vending controller.
- coin  output  2  coin code to the controller; registered.
- fifo_full  output  1  FIFO holds FIFO_DEPTH entries.
- reject  output  1  one-cycle pulse: a coin event was discarded.
- pending  output  $clog2(FIFO_DEPTH)+1  number of FIFO entries.

Behaviour:
- Reset: rst low asynchronously clears everything. coin=00, reject=0, fifo_full=0, pending=0, synchronizers=0, both detector FSMs in IDLE, gap flag clear. Removing reset is synchronous to clk.
- Synchronizer: det5 and det10 each pass through a 2-flop synchronizer. s5/s10 denote the second-stage outputs.
- Detector FSM (one per channel), states IDLE, ARM, HELD, REL:
  - IDLE: s=1 -> ARM with count=1; otherwise stay.
  - ARM: s=0 -> IDLE. s=1 and count=DEBOUNCE_CYCLES-1 -> HELD and raise the channel event for exactly one cycle. Otherwise count+1.
  - HELD: s=0 -> REL with count=1.
  - REL: s=1 -> HELD. s=0 and count=DEBOUNCE_CYCLES-1 -> IDLE. Otherwise count+1.
  - A coin held indefinitely produces exactly one event. A glitch shorter than DEBOUNCE_CYCLES produces none.
- Event arbitration, registered:
  - ev5 and ev10 in the same cycle: reject=1 and nothing is pushed (ambiguous coin).
  - A single event with FIFO full: reject=1 and nothing is pushed.
  - Otherwise the event pushes 01 (five) or 10 (ten).
- FIFO:
  - Circular buffer with read/write pointers one bit wider than the address.
  - fifo_full when pointers differ only in the MSB; empty when equal. pending equals write pointer minus read pointer.
  - Push and pop in the same cycle are both performed, including when full: the pop frees the slot, so the push is accepted and no reject is raised.
- Output pacing (coin is a registered output):
  - Issue condition, evaluated each cycle: FIFO non-empty, nw_pa=0, and gap flag clear.
  - If the condition holds: coin <= FIFO head, pop, set gap flag.
  - Otherwise: coin <= 00. The gap flag clears one cycle after it is set.
  - Result: every nonzero coin lasts exactly one cycle and is followed by at least one 00 cycle. No coin is issued while nw_pa=1.
  - Since the controller raises nw_pa one cycle after the coin that completes 15 points, the mandatory gap covers that cycle.
- Latency: with the FIFO empty and the output idle, coin shows the code DEBOUNCE_CYCLES+4 rising edges after the first edge that samples det high.
- Reset mid-operation: buffered coins are discarded and no partial code is driven.

Test Plan:
- Reset release; det5 held high 10 cycles, then low 10 cycles -> exactly one coin=01 pulse, first seen at edge 8 (N=4); pending returns to 0; reject stays 0.
- det10 bounces 1,0,1,0 at 1-cycle intervals, then stays high -> exactly one coin=10; bounce shorter than 4 cycles yields no event.
- det5 and det10 rise in the same cycle and both stay stable -> reject pulses once; coin stays 00; pending=0.
- Five coins inserted while nw_pa is forced to 1 -> pending saturates at 4 with fifo_full=1; the fifth coin gives a reject pulse. After nw_pa drops, four coins are issued in FIFO order with a 00 cycle between each.
- Against a behavioural vending-controller model: coins 01,10 back-to-back in the FIFO, then 01 queued -> 01, 00, 10, 00, hold while nw_pa=1, then 01. Exactly one nw_pa pulse occurs and no coin is issued during it.
- rst asserted low while coin=10 is being driven and pending=2 -> coin=00, pending=0, fifo_full=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/coin_acceptor.sv
// Coin detector front end: synchronizes and debounces the two detector levels,
// buffers the resulting coin events and paces them out as one-cycle codes.

module coin_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic ev
);
  typedef enum logic [1:0] {IDLE, ARM, HELD, REL} state_t;
  localparam logic [3:0] LAST = 4'(DEBOUNCE_CYCLES - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       ev_nxt;
  logic       sync1, sync2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      state <= IDLE;
      cnt   <= 4'd0;
      ev    <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      state <= state_nxt;
      cnt   <= cnt_nxt;
      ev    <= ev_nxt;
    end
  end

  // The event fires only on the ARM->HELD transition, so a held coin counts once.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ev_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (sync2) begin
          state_nxt = ARM;
          cnt_nxt   = 4'd1;
        end
      end
      ARM: begin
        if (!sync2) begin
          state_nxt = IDLE;
        end else if (cnt == LAST) begin
          state_nxt = HELD;
          ev_nxt    = 1'b1;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      HELD: begin
        if (!sync2) begin
          state_nxt = REL;
          cnt_nxt   = 4'd1;
        end
      end
      REL: begin
        if (sync2) begin
          state_nxt = HELD;
        end else if (cnt == LAST) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

module coin_acceptor #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        det5,
  input  logic                        det10,
  input  logic                        nw_pa,
  output logic [1:0]                  coin,
  output logic                        fifo_full,
  output logic                        reject,
  output logic [$clog2(FIFO_DEPTH):0] pending
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic          ev5, ev10;
  logic [AW:0]   wptr, rptr;
  logic [1:0]    mem [FIFO_DEPTH];
  logic          gap, empty, full, single, pop, push;

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db5 (
    .clk (clk),
    .rst (rst),
    .raw (det5),
    .ev  (ev5)
  );

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db10 (
    .clk (clk),
    .rst (rst),
    .raw (det10),
    .ev  (ev10)
  );

  assign empty     = (wptr == rptr);
  assign full      = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign single    = ev5 ^ ev10;
  // The gap flag forces a 00 cycle after every code, covering the cycle
  // in which the controller raises nw_pa after a completing coin.
  assign pop       = !empty && !nw_pa && !gap;
  assign push      = single && (!full || pop);
  assign fifo_full = full;
  assign pending   = wptr - rptr;

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= ev10 ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr   <= '0;
      rptr   <= '0;
      coin   <= 2'b00;
      gap    <= 1'b0;
      reject <= 1'b0;
    end else begin
      if (push) wptr <= wptr + PTR_ONE;
      if (pop)  rptr <= rptr + PTR_ONE;
      coin   <= pop ? mem[rptr[AW-1:0]] : 2'b00;
      gap    <= pop;
      reject <= (ev5 && ev10) || (single && full && !pop);
    end
  end
endmodule

// File: tb/tb_coin_acceptor.sv
// Bench for coin_acceptor: coin-level stimulus, expected codes queued per
// accepted coin, and a monitor that checks order, spacing and dispense blocking.

module tb_coin_acceptor;
  localparam int N = 4;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       det5 = 1'b0;
  logic       det10 = 1'b0;
  logic       tb_nw = 1'b0;
  logic       ctrl_nw = 1'b0;
  logic       ctrl_en = 1'b0;
  logic       nw_pa;
  logic [1:0] coin;
  logic       fifo_full;
  logic       reject;
  logic [2:0] pending;

  logic [1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int rej_seen = 0;
  int rej_exp = 0;
  int nw_pulses = 0;
  int ctrl_pts = 0;
  int ctrl_busy = 0;
  logic [1:0] prev_coin = 2'b00;
  logic       prev_nw = 1'b0;

  assign nw_pa = ctrl_en ? ctrl_nw : tb_nw;

  coin_acceptor #(.DEBOUNCE_CYCLES(N), .FIFO_DEPTH(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .det5      (det5),
    .det10     (det10),
    .nw_pa     (nw_pa),
    .coin      (coin),
    .fifo_full (fifo_full),
    .reject    (reject),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_det(input int ch, input logic v);
    if (ch == 1 || ch == 3) det5 = v;
    if (ch == 2 || ch == 3) det10 = v;
  endtask

  // ch: 1 = five, 2 = ten, 3 = both at once
  task automatic insert(input int ch, input int bounces, input int hold, input int low);
    for (int b = 0; b < bounces; b++) begin
      set_det(ch, 1'b1);
      tick();
      set_det(ch, 1'b0);
      tick();
    end
    set_det(ch, 1'b1);
    repeat (hold) tick();
    set_det(ch, 1'b0);
    repeat (low) tick();
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || pending != 3'd0) && n < 400) begin
      tick();
      n++;
    end
    repeat (3) tick();
    check({name, "_drained"}, exp_q.size(), 0);
    check({name, "_pending"}, int'(pending), 0);
  endtask

  // Monitor: every nonzero code must match the queue head, follow a 00
  // cycle, and never be issued on a cycle where nw_pa was high.
  initial begin
    logic [1:0] e;
    forever begin
      @(negedge clk);
      if (reject === 1'b1) rej_seen++;
      if (coin != 2'b00) begin
        if (exp_q.size() == 0) begin
          check("coin_unexpected", int'(coin), 0);
        end else begin
          e = exp_q.pop_front();
          check("coin_order", int'(coin), int'(e));
        end
        check("coin_gap", int'(prev_coin), 0);
        check("coin_during_nw", int'(prev_nw), 0);
      end
      prev_coin = coin;
      prev_nw   = nw_pa;
    end
  end

  // Vending controller: accumulates points, dispenses for 10 cycles at 15.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (ctrl_busy > 0) begin
        if (!ctrl_nw) nw_pulses++;
        ctrl_nw = 1'b1;
        ctrl_busy--;
      end else begin
        ctrl_nw = 1'b0;
      end
      @(negedge clk);
      if (ctrl_en && coin != 2'b00) begin
        ctrl_pts += (coin == 2'b01) ? 5 : 10;
        if (ctrl_pts >= 15) begin
          ctrl_pts -= 15;
          ctrl_busy = 10;
        end
      end
    end
  end

  initial begin
    int ch;
    int n;
    repeat (3) @(posedge clk);
    #1;
    check("rst_coin", int'(coin), 0);
    check("rst_reject", int'(reject), 0);
    check("rst_full", int'(fifo_full), 0);
    check("rst_pending", int'(pending), 0);
    tick();
    rst = 1'b1;
    repeat (3) tick();

    // Single five-point coin, with exact latency
    exp_q.push_back(2'b01);
    det5 = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    check("latency_early", int'(coin), 0);
    @(posedge clk);
    #1;
    check("latency_edge8", int'(coin), 1);
    #1;
    repeat (2) tick();
    det5 = 1'b0;
    repeat (10) tick();
    wait_drain("t1");
    check("t1_reject", rej_seen, rej_exp);

    // Bouncy ten-point coin
    exp_q.push_back(2'b10);
    insert(2, 2, 12, 12);
    wait_drain("t2");
    check("t2_reject", rej_seen, rej_exp);

    // Both detectors at once: ambiguous
    rej_exp++;
    insert(3, 0, 10, 10);
    repeat (4) tick();
    check("t3_pending", int'(pending), 0);
    check("t3_reject", rej_seen, rej_exp);

    // Five coins while dispensing: four buffered, fifth rejected
    tb_nw = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ch = int'($urandom_range(1, 2));
      if (i < 4) exp_q.push_back(2'(ch));
      else rej_exp++;
      insert(ch, 0, 8, 8);
    end
    repeat (4) tick();
    check("t4_pending", int'(pending), 4);
    check("t4_full", int'(fifo_full), 1);
    check("t4_reject", rej_seen, rej_exp);
    tb_nw = 1'b0;
    wait_drain("t4");
    check("t4_full_after", int'(fifo_full), 0);

    // Against the vending controller: 01, 10 back-to-back, then 01
    ctrl_en = 1'b1;
    exp_q.push_back(2'b01);
    exp_q.push_back(2'b10);
    exp_q.push_back(2'b01);
    det5 = 1'b1;
    tick();
    det10 = 1'b1;
    repeat (5) tick();
    det5 = 1'b0;
    tick();
    det10 = 1'b0;
    repeat (5) tick();
    insert(1, 0, 6, 8);
    wait_drain("t5");
    repeat (12) tick();
    check("t5_nw_pulses", nw_pulses, 1);
    ctrl_en = 1'b0;
    repeat (2) tick();

    // Random coins with bounces and sub-threshold glitches
    for (int i = 0; i < 8; i++) begin
      ch = int'($urandom_range(1, 2));
      if ($urandom_range(0, 2) == 0) begin
        set_det(ch, 1'b1);
        repeat ($urandom_range(1, N - 1)) tick();
        set_det(ch, 1'b0);
        repeat (N + 3) tick();
      end
      exp_q.push_back(2'(ch));
      insert(ch, int'($urandom_range(0, 2)), N + int'($urandom_range(0, 6)),
             N + int'($urandom_range(2, 6)));
    end
    wait_drain("t6");
    check("t6_reject", rej_seen, rej_exp);

    // Reset while a ten is on the output with two more buffered
    tb_nw = 1'b1;
    insert(2, 0, 8, 8);
    insert(1, 0, 8, 8);
    insert(2, 0, 8, 8);
    repeat (4) tick();
    check("t7_pending3", int'(pending), 3);
    tb_nw = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (coin != 2'b10 && n < 20);
    check("t7_coin10", int'(coin), 2);
    check("t7_pending2", int'(pending), 2);
    #1;
    rst = 1'b0;
    #1;
    check("t7_coin_rst", int'(coin), 0);
    check("t7_pending_rst", int'(pending), 0);
    check("t7_full_rst", int'(fifo_full), 0);
    repeat (2) tick();
    rst = 1'b1;
    repeat (3) tick();
    exp_q.push_back(2'b01);
    insert(1, 0, 8, 8);
    wait_drain("t7");

    check("reject_total", rej_seen, rej_exp);
    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
